regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised successor to the CPU integer register file.
- Provides NUM_RD combinational read ports and one write port with write-through bypass.
- Adds a per-register pending-write scoreboard for the pipelined hazard unit.
- Adds a sequenced soft clear, and a configurable debug tap register (a0 by default).
- Sits in the decode stage: reads and issue marks come from decode, writes come from writeback.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 5, register address width; depth is 2**ADDR_WIDTH.
- NUM_RD, 2, number of read ports (1..4).
- TAP_REG, 10, index of the register driven on the tap output.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr  in  NUM_RD*ADDR_WIDTH  packed read addresses; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- rd_data  out  NUM_RD*DATA_WIDTH  packed read data.
- rd_busy  out  NUM_RD  per-port pending flag.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- iss_en  in  1  mark a register pending (instruction issued with a destination).
- iss_addr  in  ADDR_WIDTH  register to mark.
- clr_req  in  1  request soft clear of all registers.
- clr_busy  out  1  soft clear in progress.
- tap  out  DATA_WIDTH  contents of register TAP_REG.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers 0; all busy bits 0; FSM to IDLE; clear counter 0.
  - Outputs during reset: rd_data = bypass/array value (0 unless bypassing); rd_busy = 0; clr_busy = 0; tap = 0.
  - Reset asserted mid-clear aborts the clear immediately.
- Register 0:
  - always reads 0 and is never busy.
  - Writes and issue marks to address 0 are ignored.
- Read, per port i, combinational, zero latency:
  - In IDLE, if wr_en && wr_addr == rd_addr[i] && wr_addr != 0: rd_data[i] = wr_data (bypass).
  - Otherwise rd_data[i] = array[rd_addr[i]].
  - rd_busy[i] = busy[rd_addr[i]] && !(IDLE && wr_en && wr_addr == rd_addr[i]).
- Write:
  - In IDLE, on posedge with wr_en && wr_addr != 0: array[wr_addr] <= wr_data and busy[wr_addr] <= 0.
- Issue:
  - In IDLE, on posedge with iss_en && iss_addr != 0: busy[iss_addr] <= 1.
  - If the write and the issue target the same address in the same cycle, the write updates data and busy ends at 1 (set wins).
- tap:
  - equals array[TAP_REG] from the stored value, with no bypass.
  - The tap is the registered view; it updates the cycle after a write.
- FSM IDLE:
  - clr_req high at posedge moves to CLEAR with counter <= 1.
  - clr_req is level-sampled and ignored while in CLEAR.
- FSM CLEAR:
  - Each cycle: array[counter] <= 0, busy[counter] <= 0, counter <= counter + 1.
  - When counter == 2**ADDR_WIDTH-1, that entry is cleared and the FSM returns to IDLE.
  - Duration is exactly 2**ADDR_WIDTH-1 cycles.
  - clr_busy = 1 in CLEAR.
  - wr_en and iss_en are ignored (dropped, not queued); the bypass is disabled.
  - Reads return the array contents: already-cleared entries read 0, later entries read their old values.
- Counter width is ADDR_WIDTH and counts with no wrap; the exit condition prevents overflow.
- Simultaneous clr_req and wr_en in IDLE: the write commits this edge, and the clear starts next cycle and then zeroes it.

Test Plan:
- Reset/zero:
  - Stimulus: pulse rst_n low; then write 0xDEADBEEF to r0 and set iss_en on r0.
  - Required: all rd_data = 0, rd_busy = 0, tap = 0.
  - Required: reading r0 returns 0 and not busy.
- Write/bypass:
  - Stimulus: write 0x12345678 to r5 while port0 reads r5.
  - Required: rd_data[0] = 0x12345678 in the same cycle, with rd_busy[0] = 0.
  - Required: in the next cycle with no write, the array value still reads 0x12345678.
- Scoreboard:
  - Stimulus: iss r7 at cycle 0; write r7 = 0xA5 at cycle 3.
  - Required: rd_busy = 1 during cycles 1-2 and 0 during cycle 3 (bypassed value 0xA5).
  - Stimulus: issue and write r9 in the same cycle.
  - Required: busy[r9] = 1 afterwards, and reads return the new data.
- Tap:
  - Stimulus: write 0x0000002A to r10.
  - Required: tap = 0x2A one cycle later, and tap is unaffected by writes to r11.
- Soft clear:
  - Stimulus: fill r1..r31 with nonzero values and busy bits, then pulse clr_req.
  - Required: clr_busy high for exactly 31 cycles.
  - Required: wr_en to r3 during the clear is dropped.
  - Required: afterwards all regs read 0 and all rd_busy = 0.
- Reset mid-clear:
  - Stimulus: assert rst_n low at clear cycle 10.
  - Required: clr_busy = 0 immediately and all regs 0.
  - Required: the next write to r4 commits normally.

Source files
------------

// File: rtl/regfile_sb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regfile_sb : decode-stage register file with write-through bypass, |
// |              pending-write scoreboard, sequenced clear, debug tap. |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
module regfile_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2,
    parameter int TAP_REG    = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]            rd_busy,
    input  logic                         wr_en,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic                         iss_en,
    input  logic [ADDR_WIDTH-1:0]        iss_addr,
    input  logic                         clr_req,
    output logic                         clr_busy,
    output logic [DATA_WIDTH-1:0]        tap
);

    localparam int                    c_depth    = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_first    = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] c_last     = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] c_tap      = ADDR_WIDTH'(TAP_REG);
    localparam logic [0:0]            c_st_idle  = 1'b0;
    localparam logic [0:0]            c_st_clear = 1'b1;

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [DATA_WIDTH-1:0] r_mem [c_depth];
    logic [c_depth-1:0]    r_busy;
    logic                  w_idle;
    logic                  w_wr;
    logic                  w_iss;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (clr_req)          w_state_nxt = c_st_clear;
            c_st_clear: if (r_cnt == c_last)  w_state_nxt = c_st_idle;
            default:                          w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        w_idle   = (r_state == c_st_idle);
        clr_busy = (r_state == c_st_clear);
    end

    // Register 0 is hardwired: its writes and issue marks never commit.
    assign w_wr  = w_idle && wr_en  && (wr_addr  != '0);
    assign w_iss = w_idle && iss_en && (iss_addr != '0);

    // Clear walks entries 1..last; entry 0 is already permanently zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_idle) begin
            if (clr_req) begin
                r_cnt <= c_first;
            end
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_first;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_depth; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr) begin
            r_mem[wr_addr] <= wr_data;
        end else if (!w_idle) begin
            r_mem[r_cnt] <= '0;
        end
    end

    // Issue is applied after the write so a same-address pair leaves busy set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else if (w_idle) begin
            if (w_wr) begin
                r_busy[wr_addr] <= 1'b0;
            end
            if (w_iss) begin
                r_busy[iss_addr] <= 1'b1;
            end
        end else begin
            r_busy[r_cnt] <= 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_WIDTH-1:0] w_ra;
            logic                  w_hit;

            assign w_ra  = rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_hit = w_idle && wr_en && (wr_addr == w_ra);

            assign rd_data[gi*DATA_WIDTH +: DATA_WIDTH] =
                (w_hit && (w_ra != '0)) ? wr_data : r_mem[w_ra];
            assign rd_busy[gi] = r_busy[w_ra] && !w_hit;
        end
    endgenerate

    assign tap = r_mem[c_tap];

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_regfile_sb : directed and random checks of regfile_sb against a |
// |                 behavioural register-file model.                   |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
module tb_regfile_sb;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;
    localparam int TAPR  = 10;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_busy;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             iss_en;
    logic [AW-1:0]    iss_addr;
    logic             clr_req;
    logic             clr_busy;
    logic [DW-1:0]    tap;

    regfile_sb #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_RD     (NR),
        .TAP_REG    (TAPR)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .tap      (tap)
    );

    always #5 clk = ~clk;

    // Behavioural model: plain register array, pending flags, clear progress.
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_busy [DEPTH];
    bit            m_clearing;
    int            m_next_clr;

    int total = 0;
    int bad   = 0;
    logic obs_clr;

    task automatic m_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
        m_clearing = 1'b0;
        m_next_clr = 0;
    endtask

    function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] a);
        if (!m_clearing && wr_en && (wr_addr == a) && (a != 0)) return wr_data;
        return m_mem[a];
    endfunction

    function automatic logic m_rbusy(input logic [AW-1:0] a);
        return m_busy[a] && !(!m_clearing && wr_en && (wr_addr == a));
    endfunction

    task automatic m_step();
        if (!m_clearing) begin
            if (wr_en && wr_addr != 0) begin
                m_mem[wr_addr]  = wr_data;
                m_busy[wr_addr] = 1'b0;
            end
            if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
            if (clr_req) begin
                m_clearing = 1'b1;
                m_next_clr = 1;
            end
        end else begin
            m_mem[m_next_clr]  = '0;
            m_busy[m_next_clr] = 1'b0;
            if (m_next_clr == DEPTH - 1) m_clearing = 1'b0;
            else                         m_next_clr++;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int p = 0; p < NR; p++) begin
            logic [AW-1:0] a;
            a = rd_addr[p*AW +: AW];
            chk({tag, "/rd_data"}, 64'(rd_data[p*DW +: DW]), 64'(m_rd(a)));
            chk({tag, "/rd_busy"}, 64'(rd_busy[p]), 64'(m_rbusy(a)));
        end
        chk({tag, "/clr_busy"}, 64'(clr_busy), 64'(m_clearing));
        chk({tag, "/tap"}, 64'(tap), 64'(m_mem[TAPR]));
    endtask

    task automatic settle(input string tag);
        @(negedge clk);
        obs_clr = clr_busy;
        check_all(tag);
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst_n) m_step();
        #1;
    endtask

    task automatic tick(input string tag);
        settle(tag);
        advance();
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic idle_inputs();
        wr_en = 0; wr_addr = '0; wr_data = '0;
        iss_en = 0; iss_addr = '0; clr_req = 0;
    endtask

    task automatic fill_all(input logic [DW-1:0] base);
        for (int a = 1; a < DEPTH; a++) begin
            wr_en = 1; wr_addr = AW'(a); wr_data = base + DW'(a);
            iss_en = 1; iss_addr = AW'(a);
            set_rd(AW'(a), AW'(a - 1));
            tick("fill");
        end
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_clr;

        // Reset and register 0
        rst_n = 0;
        idle_inputs();
        set_rd(5'd0, 5'd10);
        m_reset();
        settle("reset");
        chk("reset/rd0", 64'(rd_data[DW-1:0]), 64'h0);
        chk("reset/busy", 64'(rd_busy), 64'h0);
        chk("reset/tap", 64'(tap), 64'h0);
        advance();
        rst_n = 1;
        advance();
        wr_en = 1; wr_addr = 0; wr_data = 32'hDEADBEEF;
        iss_en = 1; iss_addr = 0;
        set_rd(5'd0, 5'd0);
        tick("r0_write");
        idle_inputs();
        settle("r0_read");
        chk("r0/data", 64'(rd_data[DW-1:0]), 64'h0);
        chk("r0/busy", 64'(rd_busy[0]), 64'h0);
        advance();

        // Write with bypass
        wr_en = 1; wr_addr = 5'd5; wr_data = 32'h12345678;
        set_rd(5'd5, 5'd1);
        settle("bypass");
        chk("bypass/data", 64'(rd_data[DW-1:0]), 64'h12345678);
        chk("bypass/busy", 64'(rd_busy[0]), 64'h0);
        advance();
        idle_inputs();
        settle("array_read");
        chk("array/data", 64'(rd_data[DW-1:0]), 64'h12345678);
        advance();

        // Scoreboard: issue r7, write it three cycles later
        iss_en = 1; iss_addr = 5'd7;
        set_rd(5'd7, 5'd0);
        tick("sb_c0");
        idle_inputs();
        settle("sb_c1");
        chk("sb_c1/busy", 64'(rd_busy[0]), 64'h1);
        advance();
        settle("sb_c2");
        chk("sb_c2/busy", 64'(rd_busy[0]), 64'h1);
        advance();
        wr_en = 1; wr_addr = 5'd7; wr_data = 32'hA5;
        settle("sb_c3");
        chk("sb_c3/busy", 64'(rd_busy[0]), 64'h0);
        chk("sb_c3/data", 64'(rd_data[DW-1:0]), 64'hA5);
        advance();

        // Same-cycle issue and write: set wins
        wr_en = 1; wr_addr = 5'd9; wr_data = 32'h99;
        iss_en = 1; iss_addr = 5'd9;
        set_rd(5'd0, 5'd9);
        tick("sb_same");
        idle_inputs();
        settle("sb_same_after");
        chk("sb_same/busy", 64'(rd_busy[1]), 64'h1);
        chk("sb_same/data", 64'(rd_data[2*DW-1:DW]), 64'h99);
        advance();

        // Tap
        wr_en = 1; wr_addr = 5'd10; wr_data = 32'h2A;
        tick("tap_wr");
        wr_en = 1; wr_addr = 5'd11; wr_data = 32'hFFFFFFFF;
        settle("tap_r11");
        chk("tap/after_r10", 64'(tap), 64'h2A);
        advance();
        idle_inputs();
        settle("tap_hold");
        chk("tap/after_r11", 64'(tap), 64'h2A);
        advance();

        // Soft clear with a dropped write
        fill_all(32'h1000_0000);
        clr_req = 1;
        tick("clr_req");
        clr_req = 0;
        n_clr = 0;
        for (int c = 0; c < 40; c++) begin
            if (c == 5) begin
                wr_en = 1; wr_addr = 5'd3; wr_data = 32'h3333;
                iss_en = 1; iss_addr = 5'd3;
                set_rd(5'd3, 5'd31);
            end else begin
                idle_inputs();
            end
            tick("clearing");
            if (obs_clr) n_clr++;
        end
        chk("clr/length", 64'(n_clr), 64'd31);
        for (int a = 0; a < DEPTH; a++) begin
            set_rd(AW'(a), AW'(DEPTH - 1 - a));
            settle("post_clr");
            chk("post_clr/data", 64'(rd_data), 64'h0);
            chk("post_clr/busy", 64'(rd_busy), 64'h0);
            advance();
        end

        // Reset in the middle of a clear
        fill_all(32'h2000_0100);
        clr_req = 1;
        tick("clr_req2");
        clr_req = 0;
        for (int c = 0; c < 10; c++) tick("clearing2");
        set_rd(5'd20, 5'd25);
        rst_n = 0;
        #1;
        m_reset();
        chk("midrst/clr_busy", 64'(clr_busy), 64'h0);
        chk("midrst/data", 64'(rd_data), 64'h0);
        chk("midrst/tap", 64'(tap), 64'h0);
        check_all("midrst");
        @(negedge clk);
        rst_n = 1;
        advance();
        wr_en = 1; wr_addr = 5'd4; wr_data = 32'h44;
        set_rd(5'd1, 5'd2);
        tick("r4_write");
        idle_inputs();
        set_rd(5'd4, 5'd20);
        settle("r4_read");
        chk("r4/data", 64'(rd_data[DW-1:0]), 64'h44);
        advance();

        // Random traffic with occasional clears
        for (int n = 0; n < 300; n++) begin
            logic [AW-1:0] a0;
            wr_en    = 1'($urandom_range(0, 1));
            wr_addr  = AW'($urandom_range(0, DEPTH - 1));
            wr_data  = $urandom;
            iss_en   = 1'($urandom_range(0, 1));
            iss_addr = AW'($urandom_range(0, DEPTH - 1));
            clr_req  = ($urandom_range(0, 59) == 0);
            a0 = ($urandom_range(0, 2) == 0) ? wr_addr : AW'($urandom_range(0, DEPTH - 1));
            set_rd(a0, AW'($urandom_range(0, DEPTH - 1)));
            tick("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
